mem_bus_initiator: RTL
======================

Name: mem_bus_initiator

Overview:
- Load/store initiator for the memory pipeline stage. Drives a word-addressed, byte-enabled request/acknowledge bus toward RAM or MMIO responders.
- Accepts one access from the pipeline, aligns and lane-shifts store data, and generates byte enables.
- Waits for the acknowledge, then extracts and sign- or zero-extends load data.
- Holds the pipeline with `o_busy` and reports faults: misalignment, bus error, timeout, illegal request.

Parameters:
- TIMEOUT_CYCLES, 255: cycles in REQ without `i_bus_ack` before the access is abandoned with a fault; minimum 1.
- CNT_W, 8: width of the timeout counter; must hold TIMEOUT_CYCLES.

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- rst  input  1  asynchronous, active-low reset.
- i_valid  input  1  pipeline presents an access this cycle.
- i_memr  input  1  load request.
- i_memw  input  1  store request.
- i_memt  input  Mem::memt width  access type: LoadByte, ULoadByte, LoadHalf, ULoadHalf, LoadWord, StoreByte, StoreHalf, StoreWord.
- i_addr  input  32  byte address.
- i_wdata  input  32  store data, right-aligned.
- o_busy  output  1  access in flight; the pipeline must stall and hold its inputs.
- o_done  output  1  one-cycle completion pulse.
- o_rdata  output  32  extended load result; valid while `o_done`=1.
- o_fault  output  1  completion was faulty; valid while `o_done`=1.
- o_bus_req  output  1  bus request.
- o_bus_we  output  1  1 = write.
- o_bus_addr  output  32  word address; byte address with [1:0] forced to 0.
- o_bus_be  output  4  byte-lane enables.
- o_bus_wdata  output  32  lane-shifted store data.
- i_bus_ack  input  1  responder completes the request.
- i_bus_rdata  input  32  read word; valid with `i_bus_ack`.
- i_bus_err  input  1  error; sampled only with `i_bus_ack`.

Behaviour:
- States: IDLE, REQ, DONE. `o_busy` = (state != IDLE).
- Reset, asynchronous: state=IDLE. The following are all 0: `o_done`, `o_fault`, `o_rdata`, `o_bus_req`, `o_bus_we`, `o_bus_addr`, `o_bus_be`, `o_bus_wdata`, timeout counter.
  - Reset mid-access: `o_bus_req` drops immediately. No `o_done` is produced for the aborted access.
- IDLE, `i_valid`=0, or `i_memr`=`i_memw`=0: stay IDLE; no completion.
- IDLE, `i_valid`=1, both `i_memr` and `i_memw` set, or `i_memt` inconsistent with the direction: go to DONE with `o_fault`=1. No bus request is made.
- IDLE, misaligned access (half with addr[0]=1, word with addr[1:0]!=0): go to DONE with `o_fault`=1. No bus request is made.
- IDLE, legal access: latch addr, memt and direction. Compute enables and lane data:
  - Byte: be = 0001 shifted left by addr[1:0]; wdata = i_wdata[7:0] shifted left by 8*addr[1:0].
  - Half: be = 0011 or 1100 selected by addr[1]; wdata = i_wdata[15:0] shifted left by 16*addr[1].
  - Word: be = 1111; wdata = i_wdata.
  - Go to REQ; counter cleared.
- REQ:
  - `o_bus_req`=1. addr, we, be and wdata are held stable until acknowledged.
  - Counter increments each cycle without ack.
  - `i_bus_ack`=1: deassert req next cycle, capture result, go to DONE. `o_fault` = `i_bus_err`.
  - Counter reaches TIMEOUT_CYCLES with no ack: go to DONE with `o_fault`=1.
  - An ack in the same cycle the counter expires counts as success.
- Load extraction from `i_bus_rdata`:
  - Select the lane by latched addr[1:0], as for stores.
  - LoadByte and LoadHalf sign-extend; ULoad variants zero-extend; LoadWord passes through.
  - Stores, faults and timeouts return `o_rdata`=0.
- DONE: `o_done`=1 for exactly one cycle, then IDLE. A new access can be accepted in the following cycle.
- `i_valid` while busy is ignored.
- Latency: access presented in cycle t, `o_bus_req` high in t+1. If ack arrives in t+1, `o_done` is high in t+2. Minimum 2 cycles; faults found at issue take 1 cycle.
- `i_bus_ack` outside REQ is ignored.

Test Plan:
- LoadByte at addr 0x103, responder returns 0x80AABBCC after 3 wait cycles -> be=1000, bus_addr=0x100, `o_busy` held 4 cycles, then `o_done` with `o_rdata`=0xFFFFFF80.
- StoreHalf at addr 0x202 with `i_wdata`=0x1234ABCD, zero-wait ack -> be=1100, bus_wdata=0xABCD0000, we=1, `o_done` at t+2, `o_fault`=0.
- LoadWord at 0x201 -> no `o_bus_req` ever; `o_done`=1 with `o_fault`=1 at t+1.
- ULoadHalf at 0x0, never acked, TIMEOUT_CYCLES=4 -> req high exactly 4 cycles, then `o_done` and `o_fault`, `o_rdata`=0.
- LoadWord acked with `i_bus_err`=1 -> `o_fault`=1, `o_rdata`=0. Back-to-back next access is accepted the cycle after `o_done`.
- Assert `rst` low while in REQ -> `o_bus_req`=0 immediately. After release, no `o_done` pulse and state is IDLE.

Source files
------------

// File: rtl/mem_bus_initiator.sv
// Load/store initiator for the memory stage: issues one aligned, byte-enabled bus access,
// waits for the acknowledge or a timeout, and returns extended load data or a fault.
module mem_bus_initiator #(
   parameter int unsigned TIMEOUT_CYCLES = 255,
   parameter int unsigned CNT_W          = 8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        i_valid,
   input  logic        i_memr,
   input  logic        i_memw,
   input  logic [2:0]  i_memt,
   input  logic [31:0] i_addr,
   input  logic [31:0] i_wdata,
   output logic        o_busy,
   output logic        o_done,
   output logic [31:0] o_rdata,
   output logic        o_fault,
   output logic        o_bus_req,
   output logic        o_bus_we,
   output logic [31:0] o_bus_addr,
   output logic [3:0]  o_bus_be,
   output logic [31:0] o_bus_wdata,
   input  logic        i_bus_ack,
   input  logic [31:0] i_bus_rdata,
   input  logic        i_bus_err
);

   // Access type encoding: codes 0-4 are loads, 5-7 are stores.
   localparam logic [2:0] MtLoadByte   = 3'd0;
   localparam logic [2:0] MtULoadByte  = 3'd1;
   localparam logic [2:0] MtLoadHalf   = 3'd2;
   localparam logic [2:0] MtULoadHalf  = 3'd3;
   localparam logic [2:0] MtLoadWord   = 3'd4;
   localparam logic [2:0] MtStoreByte  = 3'd5;
   localparam logic [2:0] MtStoreHalf  = 3'd6;
   localparam logic [2:0] MtStoreWord  = 3'd7;

   localparam logic [1:0] SzByte = 2'd0;
   localparam logic [1:0] SzHalf = 2'd1;
   localparam logic [1:0] SzWord = 2'd2;

   localparam logic [CNT_W-1:0] CntLast = CNT_W'(TIMEOUT_CYCLES - 1);

   typedef enum logic [1:0] {StIdle, StReq, StDone} state_e;

   state_e      state_q;
   logic        done_q;
   logic        fault_q;
   logic [31:0] rdata_q;
   logic        req_q;
   logic        we_q;
   logic [29:0] word_addr_q;
   logic [3:0]  be_q;
   logic [31:0] wdata_q;
   logic [1:0]  lane_q;
   logic [2:0]  memt_q;
   logic [CNT_W-1:0] cnt_q;

   logic        is_store;
   logic [1:0]  size;
   logic        bad_dir;
   logic        misaligned;
   logic [3:0]  be_new;
   logic [31:0] wdata_new;
   logic [7:0]  byte_lane;
   logic [15:0] half_lane;
   logic [31:0] load_data;

   always_comb begin
      is_store = (i_memt >= MtStoreByte);
      unique case (i_memt)
         MtLoadByte, MtULoadByte, MtStoreByte: size = SzByte;
         MtLoadHalf, MtULoadHalf, MtStoreHalf: size = SzHalf;
         default:                              size = SzWord;
      endcase
      bad_dir    = (i_memr && i_memw) || (i_memr && is_store) || (i_memw && !is_store);
      misaligned = ((size == SzHalf) && i_addr[0]) ||
                   ((size == SzWord) && (i_addr[1:0] != 2'b00));
      be_new    = 4'b1111;
      wdata_new = i_wdata;
      if (size == SzByte) begin
         be_new    = 4'b0001 << i_addr[1:0];
         wdata_new = {24'b0, i_wdata[7:0]} << {i_addr[1:0], 3'b000};
      end else if (size == SzHalf) begin
         be_new    = i_addr[1] ? 4'b1100 : 4'b0011;
         wdata_new = {16'b0, i_wdata[15:0]} << {i_addr[1], 4'b0000};
      end
   end

   always_comb begin
      byte_lane = 8'(i_bus_rdata >> {lane_q, 3'b000});
      half_lane = 16'(i_bus_rdata >> {lane_q[1], 4'b0000});
      unique case (memt_q)
         MtLoadByte:  load_data = {{24{byte_lane[7]}}, byte_lane};
         MtULoadByte: load_data = {24'b0, byte_lane};
         MtLoadHalf:  load_data = {{16{half_lane[15]}}, half_lane};
         MtULoadHalf: load_data = {16'b0, half_lane};
         MtLoadWord:  load_data = i_bus_rdata;
         default:     load_data = 32'b0;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= StIdle;
         done_q      <= 1'b0;
         fault_q     <= 1'b0;
         rdata_q     <= 32'b0;
         req_q       <= 1'b0;
         we_q        <= 1'b0;
         word_addr_q <= 30'b0;
         be_q        <= 4'b0;
         wdata_q     <= 32'b0;
         lane_q      <= 2'b0;
         memt_q      <= 3'b0;
         cnt_q       <= '0;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (i_valid && (i_memr || i_memw)) begin
                  if (bad_dir || misaligned) begin
                     state_q <= StDone;
                     done_q  <= 1'b1;
                     fault_q <= 1'b1;
                     rdata_q <= 32'b0;
                  end else begin
                     state_q     <= StReq;
                     req_q       <= 1'b1;
                     we_q        <= i_memw;
                     word_addr_q <= i_addr[31:2];
                     be_q        <= be_new;
                     wdata_q     <= wdata_new;
                     lane_q      <= i_addr[1:0];
                     memt_q      <= i_memt;
                     cnt_q       <= '0;
                  end
               end
            end
            StReq: begin
               // Ack is checked first so an ack on the expiry cycle still succeeds.
               if (i_bus_ack) begin
                  state_q <= StDone;
                  req_q   <= 1'b0;
                  done_q  <= 1'b1;
                  fault_q <= i_bus_err;
                  rdata_q <= i_bus_err ? 32'b0 : load_data;
               end else if (cnt_q == CntLast) begin
                  state_q <= StDone;
                  req_q   <= 1'b0;
                  done_q  <= 1'b1;
                  fault_q <= 1'b1;
                  rdata_q <= 32'b0;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            StDone: begin
               state_q <= StIdle;
               done_q  <= 1'b0;
               fault_q <= 1'b0;
               rdata_q <= 32'b0;
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   assign o_busy      = (state_q != StIdle);
   assign o_done      = done_q;
   assign o_fault     = fault_q;
   assign o_rdata     = rdata_q;
   assign o_bus_req   = req_q;
   assign o_bus_we    = we_q;
   assign o_bus_addr  = {word_addr_q, 2'b00};
   assign o_bus_be    = be_q;
   assign o_bus_wdata = wdata_q;

endmodule
